fifo_sc_fwft: RTL and testbench

FIFO_SC_FWFT -- requirements
Module: fifo_sc_fwft

---
 rtl/fifo_sc_fwft.sv | 168 ++++++++++++++++
 tb/tb_fifo_sc_fwft.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sc_fwft.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read
// behaviour, registered status flags, programmable thresholds and
// one-cycle access acknowledge/error pulses.
module fifo_sc_fwft #(
  parameter logic [8:0] dta_width         = 9'd8,
  parameter logic [8:0] addr_width        = 9'd4,
  parameter logic [8:0] prog_empty_thresh = 9'd1,
  parameter logic [8:0] prog_full_thresh  = 9'd1,
  parameter bit         fwft              = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [dta_width-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  prog_full,
  output logic [dta_width-1:0]  dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  valid,
  output logic                  underflow,
  output logic                  prog_empty,
  output logic [addr_width:0]   count
);

  localparam int dw    = int'(dta_width);
  localparam int aw    = int'(addr_width);
  localparam int depth = 1 << aw;

  typedef logic [aw-1:0] ptr_t;
  typedef logic [aw:0]   cnt_t;
  typedef logic [dw-1:0] word_t;

  localparam cnt_t full_level = cnt_t'(depth);
  localparam cnt_t pe_level   = cnt_t'(prog_empty_thresh);
  localparam cnt_t pf_level   = full_level - cnt_t'(prog_full_thresh);

`ifdef CHECK_GENERATE
  // Threshold sanity is checked once, while the instance is elaborated.
  if (int'(prog_empty_thresh) >= depth) begin : g_bad_prog_empty
    $error("fifo_sc_fwft: prog_empty_thresh %0d must be below depth %0d",
           prog_empty_thresh, depth);
  end
  if (int'(prog_full_thresh) >= depth) begin : g_bad_prog_full
    $error("fifo_sc_fwft: prog_full_thresh %0d must be below depth %0d",
           prog_full_thresh, depth);
  end
`endif

  word_t mem [depth];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  ptr_t  rd_ptr_inc;
  ptr_t  head_idx;
  cnt_t  count_next;
  cnt_t  remaining;
  logic  wr_accept;
  logic  rd_accept;
  logic  head_load;
  word_t head_next;
  logic  valid_q;

  // Access qualification, next occupancy and the next value of dout.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_accept  = wr_en && !full && !flush;
    rd_accept  = rd_en && !empty && !flush;
    rd_ptr_inc = rd_ptr + ptr_t'(1);
    head_idx   = rd_accept ? rd_ptr_inc : rd_ptr;
    remaining  = count - cnt_t'(rd_accept);
    head_load  = 1'b0;
    head_next  = dout;

    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count + cnt_t'(1);
      2'b01:   count_next = count - cnt_t'(1);
      default: count_next = count;
    endcase

    if (fwft) begin
      // dout always carries the word that will be at the head after the edge;
      // when the FIFO drains to nothing but a write lands, that word is din.
      if (remaining != '0) begin
        head_load = 1'b1;
        head_next = mem[head_idx];
      end else if (wr_accept) begin
        head_load = 1'b1;
        head_next = din;
      end
    end else if (rd_accept) begin
      head_load = 1'b1;
      head_next = mem[rd_ptr];
    end
  end

  // Storage array: written only on accepted writes.
  // NOTE: the data array has no reset; pointers and count define which
  // entries are meaningful, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, status flags, read data and access pulses.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      prog_empty <= 1'b1;
      prog_full  <= 1'b0;
      dout       <= '0;
      valid_q    <= 1'b0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      // Flush discards contents and swallows any access in the same cycle.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      prog_empty <= 1'b1;
      prog_full  <= 1'b0;
      valid_q    <= 1'b0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_accept) rd_ptr <= rd_ptr_inc;
      count      <= count_next;
      empty      <= (count_next == '0);
      full       <= (count_next == full_level);
      prog_empty <= (count_next <= pe_level);
      prog_full  <= (count_next >= pf_level);
      if (head_load) dout <= head_next;
      valid_q    <= rd_accept;
      wr_ack     <= wr_accept;
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
    end
  end

  // Standard mode flags the cycle after a read; fwft mode flags a held head.
  assign valid = fwft ? !empty : valid_q;

  // Structural invariants of the occupancy bookkeeping.
  a_count_range : assert property (@(posedge clk) disable iff (!rst)
                                   count <= full_level);
  a_empty_flag  : assert property (@(posedge clk) disable iff (!rst)
                                   empty == (count == '0));
  a_full_flag   : assert property (@(posedge clk) disable iff (!rst)
                                   full == (count == full_level));
  a_pulse_excl  : assert property (@(posedge clk) disable iff (!rst)
                                   !(wr_ack && overflow));

endmodule

// File: tb/tb_fifo_sc_fwft.sv
// Directed bench: a standard-mode and an fwft-mode instance share stimulus,
// and each scenario task compares their outputs against hand-derived values.
module tb_fifo_sc_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;

  logic       s_full, s_wr_ack, s_overflow, s_prog_full, s_empty, s_valid;
  logic       s_underflow, s_prog_empty;
  logic [7:0] s_dout;
  logic [4:0] s_count;
  logic       f_full, f_wr_ack, f_overflow, f_prog_full, f_empty, f_valid;
  logic       f_underflow, f_prog_empty;
  logic [7:0] f_dout;
  logic [4:0] f_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_q[$];

  // {count, empty, full, prog_empty, prog_full, valid, wr_ack, overflow, underflow, dout}
  logic [20:0] s_stat;
  logic [20:0] f_stat;
  localparam logic [20:0] rst_stat = {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 8'h00};
  assign s_stat = {s_count, s_empty, s_full, s_prog_empty, s_prog_full, s_valid,
                   s_wr_ack, s_overflow, s_underflow, s_dout};
  assign f_stat = {f_count, f_empty, f_full, f_prog_empty, f_prog_full, f_valid,
                   f_wr_ack, f_overflow, f_underflow, f_dout};

  always #5 clk = ~clk;

  fifo_sc_fwft #(
    .dta_width(9'd8), .addr_width(9'd4), .prog_empty_thresh(9'd2),
    .prog_full_thresh(9'd3), .fwft(1'b0)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
    .full(s_full), .wr_ack(s_wr_ack), .overflow(s_overflow),
    .prog_full(s_prog_full), .dout(s_dout), .rd_en(rd_en), .empty(s_empty),
    .valid(s_valid), .underflow(s_underflow), .prog_empty(s_prog_empty),
    .count(s_count)
  );

  fifo_sc_fwft #(
    .dta_width(9'd8), .addr_width(9'd4), .prog_empty_thresh(9'd2),
    .prog_full_thresh(9'd3), .fwft(1'b1)
  ) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
    .full(f_full), .wr_ack(f_wr_ack), .overflow(f_overflow),
    .prog_full(f_prog_full), .dout(f_dout), .rd_en(rd_en), .empty(f_empty),
    .valid(f_valid), .underflow(f_underflow), .prog_empty(f_prog_empty),
    .count(f_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (s_stat !== rst_stat) begin
      n_err++;
      $display("FAIL reset_std: got %h want %h", s_stat, rst_stat);
    end
    n_cmp++;
    if (f_stat !== rst_stat) begin
      n_err++;
      $display("FAIL reset_fwft: got %h want %h", f_stat, rst_stat);
    end
    #2 rst = 1'b1;
  endtask

  // Sixteen back-to-back writes, then one more into a full FIFO.
  task automatic test_fill();
    logic [4:0] exp_cnt;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i);
      wr_en = 1'b1;
      tick();
      exp_cnt = 5'(i + 1);
      n_cmp++;
      if ({s_count, s_wr_ack, s_full, s_prog_full, s_prog_empty, s_empty, s_valid} !==
          {exp_cnt, 1'b1, (i == 15), (i >= 12), (i <= 1), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL fill_std[%0d] {cnt,ack,full,pf,pe,empty,valid}: got %h want %h", i,
                 {s_count, s_wr_ack, s_full, s_prog_full, s_prog_empty, s_empty, s_valid},
                 {exp_cnt, 1'b1, (i == 15), (i >= 12), (i <= 1), 1'b0, 1'b0});
      end
      n_cmp++;
      if ({f_count, f_dout, f_valid} !== {exp_cnt, 8'h00, 1'b1}) begin
        n_err++;
        $display("FAIL fill_fwft[%0d] {cnt,dout,valid}: got %h want %h", i,
                 {f_count, f_dout, f_valid}, {exp_cnt, 8'h00, 1'b1});
      end
    end
    din = 8'h10;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if ({s_overflow, s_wr_ack, s_count, s_full} !== {1'b1, 1'b0, 5'd16, 1'b1}) begin
      n_err++;
      $display("FAIL fill_overflow {ovf,ack,cnt,full}: got %h want %h",
               {s_overflow, s_wr_ack, s_count, s_full}, {1'b1, 1'b0, 5'd16, 1'b1});
    end
  endtask

  // Sixteen standard-mode reads, then one read from an empty FIFO.
  task automatic test_drain();
    logic [4:0] exp_cnt;
    logic [7:0] exp_head;
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      tick();
      exp_cnt = 5'(15 - k);
      n_cmp++;
      if ({s_dout, s_valid, s_count, s_prog_empty, s_empty, s_underflow} !==
          {8'(k), 1'b1, exp_cnt, (k >= 13), (k == 15), 1'b0}) begin
        n_err++;
        $display("FAIL drain_std[%0d] {dout,valid,cnt,pe,empty,unf}: got %h want %h", k,
                 {s_dout, s_valid, s_count, s_prog_empty, s_empty, s_underflow},
                 {8'(k), 1'b1, exp_cnt, (k >= 13), (k == 15), 1'b0});
      end
      exp_head = (k == 15) ? 8'h0F : 8'(k + 1);
      n_cmp++;
      if ({f_dout, f_valid} !== {exp_head, (k != 15)}) begin
        n_err++;
        $display("FAIL drain_fwft[%0d] {dout,valid}: got %h want %h", k,
                 {f_dout, f_valid}, {exp_head, (k != 15)});
      end
    end
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({s_underflow, s_valid, s_count, s_dout} !== {1'b1, 1'b0, 5'd0, 8'h0F}) begin
      n_err++;
      $display("FAIL drain_underflow {unf,valid,cnt,dout}: got %h want %h",
               {s_underflow, s_valid, s_count, s_dout}, {1'b1, 1'b0, 5'd0, 8'h0F});
    end
    tick();
    n_cmp++;
    if ({s_underflow, s_valid, s_dout} !== {1'b0, 1'b0, 8'h0F}) begin
      n_err++;
      $display("FAIL drain_idle {unf,valid,dout}: got %h want %h",
               {s_underflow, s_valid, s_dout}, {1'b0, 1'b0, 8'h0F});
    end
  endtask

  // Head word appears without a read request; a pop empties the FIFO.
  task automatic test_fwft();
    din = 8'hA5;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if ({f_empty, f_valid, f_dout, s_valid} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
      n_err++;
      $display("FAIL fwft_write {f_empty,f_valid,f_dout,s_valid}: got %h want %h",
               {f_empty, f_valid, f_dout, s_valid}, {1'b0, 1'b1, 8'hA5, 1'b0});
    end
    tick();
    n_cmp++;
    if ({f_empty, f_valid, f_dout, f_count} !== {1'b0, 1'b1, 8'hA5, 5'd1}) begin
      n_err++;
      $display("FAIL fwft_hold {empty,valid,dout,cnt}: got %h want %h",
               {f_empty, f_valid, f_dout, f_count}, {1'b0, 1'b1, 8'hA5, 5'd1});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({f_empty, f_valid, f_count, s_dout, s_valid} !==
        {1'b1, 1'b0, 5'd0, 8'hA5, 1'b1}) begin
      n_err++;
      $display("FAIL fwft_pop {f_empty,f_valid,f_cnt,s_dout,s_valid}: got %h want %h",
               {f_empty, f_valid, f_count, s_dout, s_valid},
               {1'b1, 1'b0, 5'd0, 8'hA5, 1'b1});
    end
  endtask

  // Simultaneous write and read at the full and empty boundaries.
  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      din = 8'(8'h20 + i);
      wr_en = 1'b1;
      tick();
    end
    n_cmp++;
    if ({s_count, s_full} !== {5'd16, 1'b1}) begin
      n_err++;
      $display("FAIL sim_prefill {cnt,full}: got %h want %h",
               {s_count, s_full}, {5'd16, 1'b1});
    end
    din = 8'hEE;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if ({s_overflow, s_wr_ack, s_count, s_dout, s_valid, f_dout} !==
        {1'b1, 1'b0, 5'd15, 8'h20, 1'b1, 8'h21}) begin
      n_err++;
      $display("FAIL sim_full {ovf,ack,cnt,dout,valid,f_dout}: got %h want %h",
               {s_overflow, s_wr_ack, s_count, s_dout, s_valid, f_dout},
               {1'b1, 1'b0, 5'd15, 8'h20, 1'b1, 8'h21});
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      n_cmp++;
      if ({s_dout, s_count} !== {8'(8'h21 + k), 5'(14 - k)}) begin
        n_err++;
        $display("FAIL sim_drain[%0d] {dout,cnt}: got %h want %h", k,
                 {s_dout, s_count}, {8'(8'h21 + k), 5'(14 - k)});
      end
    end
    din = 8'h77;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_cmp++;
    if ({s_underflow, s_wr_ack, s_count, s_valid, f_dout, f_valid} !==
        {1'b1, 1'b1, 5'd1, 1'b0, 8'h77, 1'b1}) begin
      n_err++;
      $display("FAIL sim_empty {unf,ack,cnt,valid,f_dout,f_valid}: got %h want %h",
               {s_underflow, s_wr_ack, s_count, s_valid, f_dout, f_valid},
               {1'b1, 1'b1, 5'd1, 1'b0, 8'h77, 1'b1});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({s_dout, s_valid, s_count} !== {8'h77, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL sim_readback {dout,valid,cnt}: got %h want %h",
               {s_dout, s_valid, s_count}, {8'h77, 1'b1, 5'd0});
    end
  endtask

  // Forty write/read pairs over a partly filled FIFO, then a flush.
  task automatic test_wrap_flush();
    logic [7:0] exp;
    model_q.delete();
    for (int i = 0; i < 5; i++) begin
      din = 8'(8'h80 + i);
      wr_en = 1'b1;
      tick();
      model_q.push_back(din);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      din = 8'(i * 7 + 3);
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      model_q.push_back(din);
      n_cmp++;
      if ({f_dout, f_count} !== {model_q[0], 5'd6}) begin
        n_err++;
        $display("FAIL wrap_head[%0d] {f_dout,cnt}: got %h want %h", i,
                 {f_dout, f_count}, {model_q[0], 5'd6});
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp = model_q.pop_front();
      n_cmp++;
      if ({s_dout, s_valid, s_count} !== {exp, 1'b1, 5'd5}) begin
        n_err++;
        $display("FAIL wrap_read[%0d] {dout,valid,cnt}: got %h want %h", i,
                 {s_dout, s_valid, s_count}, {exp, 1'b1, 5'd5});
      end
    end
    wr_en = 1'b1;
    din = 8'h11;
    tick();
    din = 8'h12;
    tick();
    n_cmp++;
    if (s_count !== 5'd7) begin
      n_err++;
      $display("FAIL flush_pre count: got %0d want 7", s_count);
    end
    din = 8'hCC;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    model_q.delete();
    n_cmp++;
    if ({s_count, s_empty, s_full, s_prog_empty, s_prog_full, s_wr_ack, s_valid, f_valid} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL flush {cnt,empty,full,pe,pf,ack,valid,f_valid}: got %h want %h",
               {s_count, s_empty, s_full, s_prog_empty, s_prog_full, s_wr_ack, s_valid, f_valid},
               {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    din = 8'h5A;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({s_dout, s_valid, s_count} !== {8'h5A, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL flush_after {dout,valid,cnt}: got %h want %h",
               {s_dout, s_valid, s_count}, {8'h5A, 1'b1, 5'd0});
    end
  endtask

  // Reset asserted between edges with five words stored.
  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      din = 8'(8'h40 + i);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    n_cmp++;
    if (s_count !== 5'd5) begin
      n_err++;
      $display("FAIL areset_pre count: got %0d want 5", s_count);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (s_stat !== rst_stat) begin
      n_err++;
      $display("FAIL areset_std: got %h want %h", s_stat, rst_stat);
    end
    n_cmp++;
    if (f_stat !== rst_stat) begin
      n_err++;
      $display("FAIL areset_fwft: got %h want %h", f_stat, rst_stat);
    end
    #2 rst = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({s_underflow, s_count, s_empty} !== {1'b1, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL areset_after {unf,cnt,empty}: got %h want %h",
               {s_underflow, s_count, s_empty}, {1'b1, 5'd0, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_simultaneous();
    test_wrap_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
